// File: rtl/dcache_miss_controller.sv
// ---------------------------------------------------------------------------
// dcache_miss_controller
//
// Memory-stage sequencer for data-cache misses. When a load or store misses,
// it freezes the front of the pipeline (stall) and holds the MEM/WB enable
// (hit) low. It then requests the line-aligned burst from main memory and
// streams the returning beats into the cache data array. After the last beat
// it spends one DONE cycle with hit high, so the retried access, which now
// hits, is captured by MEM/WB.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   memRead, memWrite   MEM-stage load / store
//   cacheHit            tag-compare result for addr (combinational)
//   addr                MEM-stage byte address
//   hit, stall          MEM/WB enable and front-pipeline freeze (stall = ~hit)
//   memReq, memAddr     burst request and line-aligned base address
//   memGnt              request accepted by memory
//   memValid, memData   returning beat strobe and data
//   fillEn, fillIdx,    cache data-array write strobe, beat index and data
//   fillData
//   missCount           saturating count of serviced misses
// ---------------------------------------------------------------------------
module dcache_miss_controller #(
    parameter int ADDR_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     memRead,
    input  logic                     memWrite,
    input  logic                     cacheHit,
    input  logic [ADDR_W-1:0]        addr,
    output logic                     hit,
    output logic                     stall,
    output logic                     memReq,
    output logic [ADDR_W-1:0]        memAddr,
    input  logic                     memGnt,
    input  logic                     memValid,
    input  logic [63:0]              memData,
    output logic                     fillEn,
    output logic [$clog2(BEATS)-1:0] fillIdx,
    output logic [63:0]              fillData,
    output logic [31:0]              missCount
);

    localparam int OFF_W = $clog2(BEATS * 8);
    localparam int IDX_W = $clog2(BEATS);

    // Clearing the offset with a full-width mask keeps every addr bit in use.
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [IDX_W-1:0]  beat_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       miss_count_reg;
    logic              miss_detect;
    logic              last_beat;

    assign miss_detect = (memRead | memWrite) & ~cacheHit;
    assign last_beat   = (beat_reg == IDX_W'(BEATS - 1));

    // Next-state and hit decode.
    always_comb begin
        state_next = state_reg;
        hit        = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                hit = ~miss_detect;
                if (miss_detect) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                hit = 1'b0;
                if (memGnt) begin
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                hit = 1'b0;
                if (memValid && last_beat) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                // DONE: single cycle with hit high for the retried access.
                hit        = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign stall     = ~hit;
    assign memReq    = (state_reg == ST_REQ);
    assign memAddr   = mem_addr_reg;
    assign fillEn    = (state_reg == ST_FILL) & memValid;
    assign fillIdx   = beat_reg;
    assign fillData  = memData;
    assign missCount = miss_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            beat_reg       <= '0;
            mem_addr_reg   <= '0;
            miss_count_reg <= '0;
        end else begin
            state_reg <= state_next;

            // Address is captured only at detection; EX/MEM is frozen after.
            if (state_reg == ST_IDLE && miss_detect) begin
                mem_addr_reg <= addr & ~OFF_MASK;
            end

            // Counter starts each fill at zero; BEATS is a power of two so
            // the increment past the last beat wraps back to zero by itself.
            if (state_reg == ST_REQ) begin
                beat_reg <= '0;
            end else if (fillEn) begin
                beat_reg <= beat_reg + IDX_W'(1);
            end

            if (state_reg == ST_DONE && miss_count_reg != 32'hFFFF_FFFF) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_miss_controller.sv
// ---------------------------------------------------------------------------
// Testbench for dcache_miss_controller. Inputs are driven 1 time unit after
// the rising edge; outputs are checked 1 unit later, well before the next
// edge. Expected values come from a transaction-level view of a miss: the
// line-aligned address, the ordered beat stream, the hit-low duration and a
// saturating miss tally.
// ---------------------------------------------------------------------------
module tb_dcache_miss_controller;

    localparam int ADDR_W = 64;
    localparam int BEATS  = 4;
    localparam int IDX_W  = $clog2(BEATS);

    logic              clk = 1'b0;
    logic              rst;
    logic              memRead, memWrite, cacheHit;
    logic [ADDR_W-1:0] addr;
    logic              hit, stall, memReq;
    logic [ADDR_W-1:0] memAddr;
    logic              memGnt, memValid;
    logic [63:0]       memData;
    logic              fillEn;
    logic [IDX_W-1:0]  fillIdx;
    logic [63:0]       fillData;
    logic [31:0]       missCount;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_count;

    always #5 clk = ~clk;

    dcache_miss_controller #(.ADDR_W(ADDR_W), .BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .memRead(memRead), .memWrite(memWrite), .cacheHit(cacheHit), .addr(addr),
        .hit(hit), .stall(stall), .memReq(memReq), .memAddr(memAddr),
        .memGnt(memGnt), .memValid(memValid), .memData(memData),
        .fillEn(fillEn), .fillIdx(fillIdx), .fillData(fillData),
        .missCount(missCount)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Some cycles that must not start a miss: either no access or a hit.
    task automatic hit_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            memRead  = 1'($urandom_range(0, 1));
            memWrite = 1'($urandom_range(0, 1));
            cacheHit = 1'b1;
            addr     = {$urandom, $urandom};
            memGnt   = 1'($urandom_range(0, 1));
            memValid = 1'($urandom_range(0, 1));
            #1;
            chk("hitpath_hit", hit, 1);
            chk("hitpath_stall", stall, 0);
            chk("hitpath_memreq", memReq, 0);
            chk("hitpath_count", missCount, exp_count);
            $display("hit cycle: rd=%0b wr=%0b hit=%0b count=%0h", memRead, memWrite, hit, missCount);
            tick();
        end
    endtask

    // One complete miss starting in an IDLE cycle. gdelay = cycles before
    // the grant; gaps inserts missing-valid cycles (always one before beat 2).
    task automatic do_miss(input logic [63:0] a, input bit st, input int gdelay,
                           input bit gaps, input bit seq);
        logic [63:0] exp_addr;
        logic [63:0] d;
        int          low;
        int          beat;
        int          cyc;
        bit          v;
        bit          gapped;
        exp_addr = a & ~64'(BEATS * 8 - 1);
        low      = 0;
        memRead  = !st;
        memWrite = st;
        cacheHit = 1'b0;
        addr     = a;
        memGnt   = 1'b0;
        memValid = 1'b0;
        #1;
        chk("detect_hit", hit, 0);
        chk("detect_stall", stall, 1);
        chk("detect_memreq", memReq, 0);
        if (!hit) low++;
        tick();

        for (int i = 0; i <= gdelay; i++) begin
            memGnt   = (i == gdelay);
            memValid = 1'($urandom_range(0, 1));
            memData  = {$urandom, $urandom};
            #1;
            chk("req_memreq", memReq, 1);
            chk("req_memaddr", memAddr, exp_addr);
            chk("req_hit", hit, 0);
            chk("req_fillen", fillEn, 0);
            if (!hit) low++;
            tick();
        end

        beat   = 0;
        cyc    = 0;
        gapped = 0;
        while (beat < BEATS && cyc < 64) begin
            if (!gaps) v = 1;
            else if (beat == 2 && !gapped) v = 0;
            else v = 1'($urandom_range(0, 1));
            if (beat == 2 && !v) gapped = 1;
            d        = seq ? 64'hA0 + 64'(beat) : {$urandom, $urandom};
            memGnt   = 1'($urandom_range(0, 1));
            memValid = v;
            memData  = d;
            #1;
            chk("fill_memreq", memReq, 0);
            chk("fill_hit", hit, 0);
            chk("fill_stall", stall, 1);
            chk("fill_fillen", fillEn, v);
            if (v) begin
                chk("fill_idx", fillIdx, beat);
                chk("fill_data", fillData, d);
            end
            if (!hit) low++;
            beat += int'(v);
            cyc++;
            tick();
        end
        if (beat < BEATS) chk("fill_timeout", beat, BEATS);

        // DONE: retried access now hits.
        memValid = 1'b0;
        memGnt   = 1'b0;
        cacheHit = 1'b1;
        #1;
        chk("done_hit", hit, 1);
        chk("done_stall", stall, 0);
        chk("done_memreq", memReq, 0);
        chk("done_fillen", fillEn, 0);
        chk("low_cycles", low, gdelay + 2 + cyc);
        exp_count = sat_inc(exp_count);
        tick();
        chk("miss_count", missCount, exp_count);
        $display("miss: addr=%0h store=%0b line=%0h gdelay=%0d fill_cycles=%0d low=%0d count=%0h",
                 a, st, memAddr, gdelay, cyc, low, missCount);
    endtask

    initial begin
        rst      = 1'b1;
        memRead  = 1'b0;
        memWrite = 1'b0;
        cacheHit = 1'b0;
        addr     = '0;
        memGnt   = 1'b0;
        memValid = 1'b0;
        memData  = '0;
        exp_count = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_hit", hit, 1);
        chk("reset_memreq", memReq, 0);
        chk("reset_fillen", fillEn, 0);
        chk("reset_count", missCount, 0);
        chk("reset_memaddr", memAddr, 0);
        $display("reset: hit=%0b memReq=%0b count=%0h", hit, memReq, missCount);
        tick();

        // Hit path at 0x100.
        for (int i = 0; i < 3; i++) begin
            memRead  = 1'b1;
            cacheHit = 1'b1;
            addr     = 64'h100;
            #1;
            chk("t1_hit", hit, 1);
            chk("t1_stall", stall, 0);
            chk("t1_memreq", memReq, 0);
            chk("t1_count", missCount, 0);
            $display("t1 hit cycle %0d: hit=%0b", i, hit);
            tick();
        end

        // Ideal-memory read miss: line 0x1220, data 0xA0..0xA3, 6 low cycles.
        do_miss(64'h1238, 1'b0, 0, 1'b0, 1'b1);
        chk("t2_memaddr", memAddr, 64'h1220);

        // Slow memory: grant after 3 cycles, gaps between beats.
        do_miss({$urandom, $urandom}, 1'b0, 3, 1'b1, 1'b0);

        // Back-to-back: store miss then immediate load miss.
        do_miss(64'h40, 1'b1, 0, 1'b0, 1'b0);
        do_miss(64'h2000, 1'b0, 0, 1'b0, 1'b0);

        // Randomised misses with hit cycles in between.
        for (int r = 0; r < 6; r++) begin
            hit_cycles($urandom_range(0, 2));
            do_miss({$urandom, $urandom}, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset in the middle of a fill.
        memRead  = 1'b1;
        memWrite = 1'b0;
        cacheHit = 1'b0;
        addr     = 64'h3008;
        tick();
        memGnt = 1'b1;
        tick();
        memGnt   = 1'b0;
        memValid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        memRead  = 1'b0;
        memValid = 1'b1;
        exp_count = '0;
        #1;
        chk("t5_memreq", memReq, 0);
        chk("t5_fillen", fillEn, 0);
        chk("t5_hit", hit, 1);
        chk("t5_count", missCount, 0);
        chk("t5_memaddr", memAddr, 0);
        $display("t5 after reset: memReq=%0b fillEn=%0b count=%0h", memReq, fillEn, missCount);
        tick();
        memValid = 1'b0;
        do_miss(64'h3008, 1'b0, 1, 1'b0, 1'b0);

        // Saturation.
        force dut.miss_count_reg = 32'hFFFF_FFFE;
        tick();
        release dut.miss_count_reg;
        exp_count = 32'hFFFF_FFFE;
        #1;
        chk("t6_preload", missCount, exp_count);
        do_miss(64'h5000, 1'b0, 0, 1'b0, 1'b0);
        do_miss(64'h6000, 1'b1, 1, 1'b1, 1'b0);
        chk("t6_saturated", missCount, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
